// File: rtl/c499_scrub_ctrl.sv
// c499_scrub_ctrl: walks DEPTH memory words through an external c499 corrector and writes back changed words.
module c499_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [7:0]        mem_rcheck,
  input  logic              mem_ack,
  output logic [31:0]       ecc_din,
  output logic [7:0]        ecc_chk,
  output logic              ecc_en,
  input  logic [31:0]       ecc_dout,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [ADDR_W-1:0] last_err_addr
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] EVAL = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] NEXT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word_q, fix_q;
  logic [7:0]        chk_q;
  logic              abort_q;
  logic              last_word, changed;
  assign last_word = addr == ADDR_W'(DEPTH - 1);
  assign changed   = ecc_dout != word_q;
  assign ecc_en    = state == EVAL;
  assign ecc_din   = ecc_en ? word_q : '0;
  assign ecc_chk   = ecc_en ? chk_q : '0;
  assign mem_addr  = addr;
  assign mem_wdata = fix_q;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start ? RD : IDLE;
      RD:      state_n = mem_ack ? EVAL : RD;
      EVAL:    state_n = changed ? WR : NEXT;
      WR:      state_n = mem_ack ? NEXT : WR;
      NEXT:    state_n = (last_word || abort_q) ? DONE : RD;
      default: state_n = IDLE;
    endcase
  end
  // Handshake outputs are registered from the next state so they rise with the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      addr          <= '0;
      word_q        <= '0;
      chk_q         <= '0;
      fix_q         <= '0;
      abort_q       <= 1'b0;
      corr_cnt      <= '0;
      last_err_addr <= '0;
    end else begin
      state   <= state_n;
      busy    <= state_n != IDLE;
      done    <= state_n == DONE;
      mem_req <= state_n == RD || state_n == WR;
      mem_we  <= state_n == WR;
      abort_q <= (state_n == IDLE) ? 1'b0 : abort_q | ((state != IDLE) & abort);
      if (state == IDLE && start) begin
        corr_cnt      <= '0;
        last_err_addr <= '0;
        addr          <= '0;
      end
      if (state == RD && mem_ack) begin
        word_q <= mem_rdata;
        chk_q  <= mem_rcheck;
      end
      if (state == EVAL) begin
        fix_q <= ecc_dout;
        if (changed) begin
          corr_cnt      <= (&corr_cnt) ? corr_cnt : corr_cnt + 1'b1;
          last_err_addr <= addr;
        end
      end
      if (state == NEXT && !last_word && !abort_q) addr <= addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_c499_scrub_ctrl.sv
// tb_c499_scrub_ctrl: directed scrub passes against a memory/corrector model with per-cycle transaction checks.
module tb_c499_scrub_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        start, abort, busy, done, mem_req, mem_we, ecc_en;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_addr, ecc_chk, last_err_addr;
  logic [7:0]  mem_rcheck = '0;
  logic [31:0] mem_wdata, ecc_din, ecc_dout;
  logic [31:0] mem_rdata = '0;
  logic [15:0] corr_cnt;
  logic        start_b, abort_b, busy_b, done_b, mem_req_b, mem_we_b, ecc_en_b;
  logic        mem_ack_b = 1'b0;
  logic [7:0]  mem_addr_b, ecc_chk_b, last_err_addr_b;
  logic [7:0]  mem_rcheck_b = '0;
  logic [31:0] mem_wdata_b, ecc_din_b, ecc_dout_b;
  logic [31:0] mem_rdata_b = '0;
  logic [1:0]  corr_cnt_b;
  c499_scrub_ctrl #(.ADDR_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rcheck(mem_rcheck), .mem_ack(mem_ack),
    .ecc_din(ecc_din), .ecc_chk(ecc_chk), .ecc_en(ecc_en), .ecc_dout(ecc_dout),
    .corr_cnt(corr_cnt), .last_err_addr(last_err_addr));
  c499_scrub_ctrl #(.ADDR_W(8), .DEPTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .mem_rcheck(mem_rcheck_b), .mem_ack(mem_ack_b),
    .ecc_din(ecc_din_b), .ecc_chk(ecc_chk_b), .ecc_en(ecc_en_b), .ecc_dout(ecc_dout_b),
    .corr_cnt(corr_cnt_b), .last_err_addr(last_err_addr_b));
  // Stand-in SEC corrector: every data bit owns a distinct syndrome of weight >= 2.
  function automatic logic [7:0] code(int i);
    return 8'h60 | 8'(i);
  endfunction
  function automatic logic [7:0] enc(logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= code(i);
    return c;
  endfunction
  function automatic logic [31:0] fixw(logic [31:0] d, logic [7:0] c, logic en);
    logic [7:0]  s;
    logic [31:0] r;
    s = enc(d) ^ c;
    r = d;
    if (en) for (int i = 0; i < 32; i++) if (s == code(i)) r[i] = ~r[i];
    return r;
  endfunction
  assign ecc_dout   = fixw(ecc_din, ecc_chk, ecc_en);
  assign ecc_dout_b = fixw(ecc_din_b, ecc_chk_b, ecc_en_b);
  int n_chk = 0, n_fail = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {logic [7:0] a; logic we; logic [31:0] d;} txn_t;
  txn_t        exp_q[$];
  txn_t        e;
  logic [31:0] orig[4], mdata[4];
  logic [7:0]  mchk[4];
  int          nrd, nwr, busy_cyc, ecnt, elast, maxd = 0, wcnt = -1;
  bit          spur = 0, hold_wr = 0;
  logic        prev_req = 0, prev_ack = 0, prev_we = 0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_wd = '0;
  // Memory responder and per-cycle compare against the expected transaction list.
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (ecc_en) begin
      check("ecc_din", ecc_din, mdata[mem_addr[1:0]]);
      check("ecc_chk", ecc_chk, mchk[mem_addr[1:0]]);
    end
    if (mem_req && prev_req && !prev_ack) begin
      check("addr_stable", mem_addr, prev_addr);
      check("we_stable", mem_we, prev_we);
      check("wdata_stable", mem_wdata, prev_wd);
    end
    prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wd = mem_wdata;
    if (rst || !mem_req) begin
      wcnt = -1;
      mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      mem_rcheck = 8'($urandom);
    end else begin
      if (wcnt < 0) wcnt = (maxd > 0) ? int'($urandom_range(0, maxd)) : 0;
      if (wcnt == 0 && !(mem_we && hold_wr)) begin
        mem_ack = 1'b1;
        wcnt = -1;
        check("txn_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("txn_addr", mem_addr, e.a);
          check("txn_we", mem_we, e.we);
          if (e.we) check("txn_wdata", mem_wdata, e.d);
        end
        if (mem_we) begin
          mdata[mem_addr[1:0]] = mem_wdata;
          nwr++;
        end else begin
          mem_rdata = mdata[mem_addr[1:0]];
          mem_rcheck = mchk[mem_addr[1:0]];
          nrd++;
        end
      end else begin
        mem_ack = 1'b0;
        if (wcnt > 0) wcnt--;
      end
    end
    prev_ack = mem_ack;
  end
  logic [31:0] ob[8], mdata_b[8];
  logic [7:0]  mchk_b[8];
  int          nrd_b = 0, nwr_b = 0, bcyc_b = 0;
  always @(negedge clk) begin
    if (busy_b) bcyc_b++;
    mem_ack_b = mem_req_b;
    if (mem_req_b && mem_we_b) begin
      mdata_b[mem_addr_b[2:0]] = mem_wdata_b;
      nwr_b++;
    end else if (mem_req_b) begin
      mem_rdata_b = mdata_b[mem_addr_b[2:0]];
      mem_rcheck_b = mchk_b[mem_addr_b[2:0]];
      nrd_b++;
    end
  end
  task automatic load_clean();
    for (int i = 0; i < 4; i++) begin
      mdata[i] = orig[i];
      mchk[i] = enc(orig[i]);
    end
  endtask
  // Model: every word up to the last visited is read; a word differing from its original is rewritten.
  task automatic plan(int last);
    exp_q.delete();
    ecnt = 0; elast = 0; nrd = 0; nwr = 0; busy_cyc = 0;
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back('{a: 8'(a), we: 1'b0, d: 32'h0});
      if (mdata[a] != orig[a]) begin
        exp_q.push_back('{a: 8'(a), we: 1'b1, d: orig[a]});
        ecnt++;
        elast = a;
      end
    end
  endtask
  task automatic run(int abort_at);
    bit ok, fired;
    ok = 0; fired = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("req_after_start", mem_req, 1);
    check("first_addr", mem_addr, 0);
    check("cnt_cleared", corr_cnt, 0);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      abort = 1'b0;
      if (abort_at >= 0 && !fired && mem_req && !mem_we && mem_addr == 8'(abort_at)) begin
        abort = 1'b1;
        fired = 1;
      end
      if (done) ok = 1;
    end
    abort = 1'b0;
    check("done_seen", 32'(ok), 1);
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("queue_drained", exp_q.size(), 0);
    check("model_cnt", corr_cnt, ecnt);
    check("model_last", last_err_addr, elast);
  endtask
  initial begin
    bit seen;
    int bad;
    start = 0; abort = 0; start_b = 0; abort_b = 0;
    orig[0] = 32'h1234_5678; orig[1] = 32'hdead_beef; orig[2] = 32'h0000_0000; orig[3] = 32'hffff_ffff;
    load_clean();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cnt", corr_cnt, 0);
    check("rst_last", last_err_addr, 0);
    check("rst_ecc_en", ecc_en, 0);
    rst = 1'b0;
    @(negedge clk);
    plan(3);
    run(-1);
    check("t1_cycles", busy_cyc, 13);
    check("t1_reads", nrd, 4);
    check("t1_writes", nwr, 0);
    check("t1_cnt", corr_cnt, 0);
    load_clean();
    mdata[2] ^= 32'h20;
    plan(3);
    run(-1);
    check("t2_cycles", busy_cyc, 14);
    check("t2_writes", nwr, 1);
    check("t2_fixed", mdata[2], 32'h0);
    check("t2_cnt", corr_cnt, 1);
    check("t2_last", last_err_addr, 2);
    load_clean();
    mdata[0] ^= 32'h1;
    mdata[3] ^= 32'h8000_0000;
    maxd = 3; spur = 1;
    plan(3);
    run(-1);
    maxd = 0; spur = 0;
    check("t3_cnt", corr_cnt, 2);
    check("t3_last", last_err_addr, 3);
    check("t3_writes", nwr, 2);
    check("t3_word3", mdata[3], 32'hffff_ffff);
    load_clean();
    mdata[1] ^= 32'h100;
    plan(1);
    run(1);
    check("t4_cnt", corr_cnt, 1);
    check("t4_last", last_err_addr, 1);
    check("t4_reads", nrd, 2);
    check("t4_writes", nwr, 1);
    check("t4_fixed", mdata[1], 32'hdead_beef);
    load_clean();
    mdata[0] ^= 32'h4;
    plan(3);
    hold_wr = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1;
    end
    check("t6_reached_wr", 32'(seen), 1);
    check("t6_cnt_before", corr_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_req", mem_req, 0);
    check("t6_busy", busy, 0);
    check("t6_we", mem_we, 0);
    check("t6_cnt", corr_cnt, 0);
    check("t6_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_wr = 0;
    check("t6_no_write", mdata[0], 32'h1234_567c);
    plan(3);
    run(-1);
    check("t6_cycles", busy_cyc, 14);
    check("t6_writes", nwr, 1);
    check("t6_last", last_err_addr, 0);
    for (int i = 0; i < 8; i++) begin
      ob[i] = $urandom;
      mchk_b[i] = enc(ob[i]);
      mdata_b[i] = ob[i] ^ (32'h1 << (i * 3));
    end
    bcyc_b = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_b) seen = 1;
    end
    check("t5_done_seen", 32'(seen), 1);
    @(negedge clk);
    check("t5_cnt_sat", corr_cnt_b, 3);
    check("t5_writes", nwr_b, 8);
    check("t5_reads", nrd_b, 8);
    check("t5_cycles", bcyc_b, 33);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mdata_b[i] != ob[i]) bad++;
    check("t5_all_fixed", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/c499_scrub_ctrl.md
# c499_scrub_ctrl

Sequential scrub controller for the 32-bit single-error-correcting datapath (c499 corrector: 32 data bits, 8 check bits, check-enable input, 32 corrected outputs). It walks a protected memory of DEPTH words and presents each word and its check byte to the combinational corrector. It writes corrected data back whenever the corrector changed the word, and keeps a saturating correction count plus the last corrected address. It sits between the memory port and an external c499 instance; the corrector itself is not part of this block.

## Interface
- ADDR_W, 8, memory address width
- DEPTH, 256, words scrubbed per pass (addresses 0..DEPTH-1, DEPTH ≤ 2^ADDR_W)
- CNT_W, 16, correction counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  end the pass early, after the current memory transaction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data (corrected word)
- mem_rdata  in  32  read data; valid with mem_ack on a read
- mem_rcheck  in  8  stored check byte; valid with mem_ack on a read
- mem_ack  in  1  one-cycle completion strobe; may assert in the first cycle mem_req is high
- ecc_din  out  32  data to corrector (maps to N1..N125)
- ecc_chk  out  8  check bits to corrector (maps to N129..N136)
- ecc_en  out  1  check enable to corrector (maps to N137)
- ecc_dout  in  32  corrected data from corrector (N724..N755)
- corr_cnt  out  CNT_W  corrections this pass, saturating
- last_err_addr  out  ADDR_W  address of most recent correction

## Operation
- Reset values: state IDLE, all outputs 0, internal address 0.
- FSM states: IDLE, RD, EVAL, WR, NEXT, DONE.
- IDLE: when start=1, clear corr_cnt, last_err_addr and the address, then go to RD.
- RD: mem_req=1, mem_we=0, mem_addr=address. On mem_ack, register mem_rdata into word_q and mem_rcheck into chk_q, then go to EVAL.
- EVAL: lasts exactly one cycle. ecc_din=word_q, ecc_chk=chk_q, ecc_en=1; ecc_en is 0 in all other states. Register ecc_dout into fix_q.
  - If ecc_dout ≠ word_q: increment corr_cnt (hold at all-ones, no wrap), load last_err_addr with the address, go to WR.
  - Otherwise go to NEXT.
- WR: mem_req=1, mem_we=1, mem_wdata=fix_q, same address. The check byte is not rewritten. On mem_ack, go to NEXT.
- NEXT: if the address is DEPTH-1 or abort is latched, go to DONE. Otherwise increment the address and go to RD.
- DONE: done=1 for one cycle, then go to IDLE. corr_cnt and last_err_addr hold until the next accepted start.
- abort: captured into a sticky flag in any non-IDLE state and cleared on entry to IDLE.
  - It never drops mem_req before mem_ack.
  - Asserted in RD, the read completes and that word is still evaluated and written back if needed.
  - Asserted in EVAL or WR, the current word finishes.
  - The pass ends at the following NEXT.
- start while busy=1 is ignored.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req is high.

## Timing
- All outputs are registered except ecc_din, ecc_chk and ecc_en. These are decoded from state and registers and are stable for the whole EVAL cycle.
- start sampled at edge k: busy=1 and mem_req=1 from cycle k+1.
- Zero-wait memory (ack in the first req cycle):
  - clean word = 3 cycles (RD, EVAL, NEXT)
  - corrected word = 4 cycles (adds WR)
  - clean pass = 3·DEPTH + 1 cycles from start acceptance to the end of the done pulse
- Each wait state on mem_ack adds one cycle to RD or WR.
- rst mid-pass: immediate return to IDLE; mem_req and all outputs go to 0 asynchronously; no write is completed.
- A mem_ack arriving while mem_req=0 is ignored.

## Test plan
- DEPTH=4, all words clean, zero-wait memory, start pulse → 4 reads, no writes, done exactly 13 cycles after start is accepted, corr_cnt=0.
- Word 2 stored with data bit 5 flipped (check byte from the original data) → one write at address 2 with the original data, corr_cnt=1, last_err_addr=2, pass takes 14 cycles.
- Random 0–3 cycle ack delays with errors at addresses 0 and 3 → mem_addr, mem_we and mem_wdata stable throughout every request; corr_cnt=2; last_err_addr=3.
- abort pulsed during the read of address 1 while that word has an error → word 1 is corrected and written back, no request to address 2, done pulses, corr_cnt=1.
- CNT_W=2, DEPTH=8, every word corrupted → corr_cnt saturates at 3 and does not wrap; 8 writes issued.
- rst asserted during WR, then start again → mem_req drops at once, outputs are 0, and the new pass begins at address 0 with corr_cnt cleared.
